// File: rtl/load_store_unit.sv
// Load/store unit: decodes core loads/stores into one or two aligned bus beats, merges and extends load data.
// Latency: accept to resp_valid is 3 cycles aligned, 5 cycles split, 1 cycle fault (zero-wait bus).
// Backpressure: req_ready only in IDLE; bus beats are held stable until mem_gnt, so a slow grant stalls the unit.
module load_store_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [XLEN-1:0]     reg_data,
  output logic                resp_valid,
  output logic [XLEN-1:0]     load_data,
  output logic                fault,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        func3_q, func3_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              store_q, store_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   rdata1_q, rdata1_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;

  // Incoming request decode
  logic       in_is_ls, in_is_store, in_illegal, in_misal;
  logic [3:0] in_size;

  // Captured request decode
  logic [OFF_W-1:0]  off_c;
  logic [OFF_W:0]    shb_c;
  logic [3:0]        size_c;
  logic [BYTES-1:0]  size_mask;
  logic              split_c;
  logic [ADDR_W-1:0] base_addr;
  logic [2*XLEN-1:0] comb_rd;
  logic [XLEN-1:0]   raw_ld, ext_ld, load_res;
  int                ext_sh;

  // Decode the request on the input pins to decide fault vs. bus access at accept time
  always_comb begin
    in_is_store = (opcode == OP_STORE);
    in_is_ls    = (opcode == OP_LOAD) || in_is_store;
    in_size     = 4'd1 << func3[1:0];
    in_illegal  = (func3 == 3'b111) ||
                  (((func3 == 3'b011) || (func3 == 3'b110)) && (XLEN != 64)) ||
                  (in_is_store && func3[2]);
    // "Misaligned" is relative to the access size, not the bus width
    in_misal    = (({1'b0, addr[2:0]} & (in_size - 4'd1)) != 4'd0);
  end

  // Beat geometry and load merge/extension derived from the captured request
  always_comb begin
    off_c     = addr_q[OFF_W-1:0];
    shb_c     = (OFF_W+1)'(BYTES) - {1'b0, off_c};
    size_c    = 4'd1 << func3_q[1:0];
    size_mask = '0;
    for (int i = 0; i < BYTES; i++) size_mask[i] = (i < int'(size_c));
    split_c   = (int'(off_c) + int'(size_c)) > BYTES;
    base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    // Beat 2 bytes sit above beat 1 bytes; a single beat leaves the upper half zero
    comb_rd   = split_c ? {mem_rdata, rdata1_q} : {{XLEN{1'b0}}, mem_rdata};
    raw_ld    = XLEN'(comb_rd >> {off_c, 3'b000});
    ext_sh    = XLEN - 8 * int'(size_c);
    if (ext_sh < 0) ext_sh = 0;
    ext_ld    = raw_ld << ext_sh;
    load_res  = func3_q[2] ? (ext_ld >> ext_sh) : XLEN'($signed(ext_ld) >>> ext_sh);
  end

  // Next-state logic and request/response bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    func3_d     = func3_q;
    wdata_d     = wdata_q;
    store_d     = store_q;
    fault_d     = fault_q;
    rdata1_d    = rdata1_q;
    load_data_d = load_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && in_is_ls) begin
          addr_d  = addr;
          func3_d = func3;
          wdata_d = reg_data;
          store_d = in_is_store;
          if (in_illegal || (!ALLOW_MISALIGNED && in_misal)) begin
            fault_d     = 1'b1;
            load_data_d = '0;
            state_d     = S_RESP;
          end else begin
            fault_d = 1'b0;
            state_d = S_REQ1;
          end
        end
      end
      S_REQ1:  if (mem_gnt) state_d = S_WAIT1;
      S_WAIT1: begin
        if (mem_rvalid) begin
          rdata1_d = mem_rdata;
          if (split_c) begin
            state_d = S_REQ2;
          end else begin
            load_data_d = store_q ? '0 : load_res;
            state_d     = S_RESP;
          end
        end
      end
      S_REQ2:  if (mem_gnt) state_d = S_WAIT2;
      S_WAIT2: begin
        if (mem_rvalid) begin
          load_data_d = store_q ? '0 : load_res;
          state_d     = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and core-facing outputs decoded from state; beat fields are zero outside REQ states
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    resp_valid = (state_q == S_RESP);
    fault      = resp_valid && fault_q;
    load_data  = load_data_q;
    mem_req    = (state_q == S_REQ1) || (state_q == S_REQ2);
    mem_we     = mem_req && store_q;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    if (state_q == S_REQ1) begin
      mem_addr  = base_addr;
      mem_be    = size_mask << off_c;
      mem_wdata = wdata_q << {off_c, 3'b000};
    end else if (state_q == S_REQ2) begin
      mem_addr  = base_addr + ADDR_W'(BYTES);
      mem_be    = size_mask >> shb_c;
      mem_wdata = wdata_q >> {shb_c, 3'b000};
    end
  end

  // State and captured-request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      func3_q     <= '0;
      wdata_q     <= '0;
      store_q     <= 1'b0;
      fault_q     <= 1'b0;
      rdata1_q    <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      func3_q     <= func3_d;
      wdata_q     <= wdata_d;
      store_q     <= store_d;
      fault_q     <= fault_d;
      rdata1_q    <= rdata1_d;
      load_data_q <= load_data_d;
    end
  end

endmodule
